gf180mcu_mux2_sel_arb: RTL
==========================

Name: gf180mcu_mux2_sel_arb

Overview:
- Registered select controller that sits directly upstream of a 2:1 mux cell and drives its S pin.
- Arbitrates between two requesting sources (I0 side, I1 side) using round-robin priority with a per-grant beat limit.
- Emits glitch-free, registered S and one-hot grant strobes, so the downstream mux only ever sees S change on a clock edge.

Parameters:
- BURST_W, 4, width of the BURST limit input and of the internal beat counter.

Ports:
- CLK     input   1        rising-edge clock
- RST     input   1        synchronous, active-high reset
- REQ0    input   1        source 0 (mux I0 side) requests the path
- REQ1    input   1        source 1 (mux I1 side) requests the path
- ADV     input   1        one beat consumed downstream this cycle; ignored when no grant is active
- BURST   input   BURST_W  max beats per grant; 0 = unlimited; sampled live every cycle
- S       output  1        registered select to the mux: 0 = I0, 1 = I1
- GNT0    output  1        registered, source 0 currently owns the path
- GNT1    output  1        registered, source 1 currently owns the path
- BUSY    output  1        registered, GNT0 | GNT1, or switch gap in progress

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=IDLE, S=0, GNT0=0, GNT1=0, BUSY=0, cnt=0.
  - Priority pointer set so REQ0 wins the first tie.
  - RST overrides everything, including mid-grant; outputs take reset values at that edge.
- States: IDLE, GRANT0, GRANT1, plus GAP when the optional feature is enabled.
- IDLE:
  - Only REQ0 -> GRANT0.
  - Only REQ1 -> GRANT1.
  - Both -> the source not served last.
  - Neither -> stay in IDLE; S holds its last value.
  - Latency: request seen at edge n gives GNTx=1 and S=x after edge n.
- GRANTx:
  - cnt increments on each ADV and saturates at all-ones.
  - Terminal beat: ADV=1 and BURST!=0 and cnt+1 >= BURST.
  - Release when the terminal beat occurs, or when REQx=0 (a beat with ADV in the same cycle still counts).
  - On release, the other source requesting -> GRANT(other), same edge, S flips and GNT swaps.
  - On release, only REQx still requesting -> re-grant x (GRANTx again).
  - On release, no requests -> IDLE.
  - cnt clears to 0 on every grant change or re-grant.
  - BURST=0 -> grant held for as long as REQx stays high.
- Priority pointer: updated to "last served = x" whenever GRANTx is left.
- Grant invariants:
  - GNT0 and GNT1 are never both 1.
  - S always equals the index of the active grant.
  - S changes only on the same edge at which a grant change occurs.
- BURST lowered mid-grant below cnt+1: the next ADV is terminal.
- No grant while ADV=1: ADV has no effect.

Optional Feature:
- Macro: GF180MCU_MUX2_SEL_GAP_EN.
- Defined:
  - Any handover from GRANTx to GRANT(other) passes through one GAP cycle.
  - In GAP: GNT0=GNT1=0, BUSY=1, S holds the old value.
  - S changes at the edge that exits GAP, together with the new GNT.
  - Requests are re-evaluated at GAP exit with the other source preferred; none -> IDLE.
  - Re-grant of the same source and IDLE entry take no gap.
- Undefined:
  - Direct handover on the same edge; GAP state not present.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ0=REQ1=1 -> S=0, GNT0=GNT1=0, BUSY=0; first edge after RST drops gives GNT0=1, S=0.
- Burst limit: BURST=3, REQ0=REQ1=1, ADV=1 every cycle -> GNT0 for 3 cycles, then GNT1 with S=1 for 3 cycles, alternating; cnt never exceeds 2.
- Unlimited: BURST=0, REQ1 only, 20 ADV beats -> GNT1 stays 1 for all 20; drop REQ1 -> IDLE next edge with S held at 1.
- Early drop: BURST=8, GRANT0 after 2 beats, REQ0 falls while REQ1=1 -> GNT1=1, S=1 on the next edge; cnt restarts at 0.
- Mid-grant reset: RST asserted during GRANT1 with cnt=5 -> S=0, GNT1=0 at that edge; next grant with both requesting goes to REQ0.
- Gap feature (macro defined): BURST=1, both requesting -> GNT pattern 0,gap,1,gap,0; during gap S holds, BUSY=1, GNT0=GNT1=0.

Source files
------------

// File: rtl/gf180mcu_mux2_sel_arb.sv
// Registered round-robin select controller driving the S pin of a 2:1 mux.
// Optional handover gap cycle: define GF180MCU_MUX2_SEL_GAP_EN.
`default_nettype none

module gf180mcu_mux2_sel_arb #(
  parameter int BURST_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0,
  input  logic               REQ1,
  input  logic               ADV,
  input  logic [BURST_W-1:0] BURST,
  output logic               S,
  output logic               GNT0,
  output logic               GNT1,
  output logic               BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  state_t             w_handover;
  logic [BURST_W-1:0] r_cnt;
  logic [BURST_W-1:0] w_cnt_nxt;
  logic               r_last;
  logic               w_last_nxt;
  logic               r_s;
  logic               r_gnt0;
  logic               r_gnt1;
  logic               r_busy;
  logic               w_s_nxt;
  logic               w_gnt0_nxt;
  logic               w_gnt1_nxt;
  logic               w_busy_nxt;
  logic [BURST_W:0]   w_cnt_inc;
  logic               w_term;
  logic               w_own_req;
  logic               w_oth_req;
  logic               w_release;
  logic               w_pick_vld;
  logic               w_pick;
  logic               w_in_g1;

  assign w_in_g1    = (r_state == ST_GRANT1);
  assign w_own_req  = w_in_g1 ? REQ1 : REQ0;
  assign w_oth_req  = w_in_g1 ? REQ0 : REQ1;
  assign w_cnt_inc  = {1'b0, r_cnt} + {{BURST_W{1'b0}}, 1'b1};
  assign w_term     = ADV && (|BURST) &&
                      (w_cnt_inc >= {1'b0, BURST});
  assign w_release  = w_term || !w_own_req;
  // r_last names the source served last; the other one wins a tie
  assign w_pick_vld = REQ0 | REQ1;
  assign w_pick     = (REQ0 & REQ1) ? ~r_last : REQ1;

`ifdef GF180MCU_MUX2_SEL_GAP_EN
  assign w_handover = ST_GAP;
`else
  assign w_handover = w_in_g1 ? ST_GRANT0 : ST_GRANT1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_s     <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_s     <= w_s_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    unique case (r_state)
      ST_IDLE, ST_GAP: begin
        w_cnt_nxt = '0;
        if (w_pick_vld)
          w_state_nxt = w_pick ? ST_GRANT1 : ST_GRANT0;
        else
          w_state_nxt = ST_IDLE;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (w_release) begin
          w_last_nxt = w_in_g1;
          w_cnt_nxt  = '0;
          if (w_oth_req)
            w_state_nxt = w_handover;
          else if (w_own_req)
            w_state_nxt = r_state;
          else
            w_state_nxt = ST_IDLE;
        end else if (ADV && !(&r_cnt)) begin
          w_cnt_nxt = w_cnt_inc[BURST_W-1:0];
        end
      end
    endcase
  end

  // S only moves when a grant is actually taken; IDLE and GAP hold it
  always_comb begin
    w_s_nxt    = r_s;
    w_gnt0_nxt = 1'b0;
    w_gnt1_nxt = 1'b0;
    w_busy_nxt = 1'b0;
    unique case (1'b1)
      (w_state_nxt == ST_GRANT0): begin
        w_s_nxt    = 1'b0;
        w_gnt0_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      (w_state_nxt == ST_GRANT1): begin
        w_s_nxt    = 1'b1;
        w_gnt1_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      (w_state_nxt == ST_GAP): begin
        w_busy_nxt = 1'b1;
      end
      (w_state_nxt == ST_IDLE): begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign S    = r_s;
  assign GNT0 = r_gnt0;
  assign GNT1 = r_gnt1;
  assign BUSY = r_busy;

endmodule

`default_nettype wire
